sdio_bus_target: RTL and testbench

SDIO_BUS_TARGET -- requirements
Module: sdio_bus_target

---
 rtl/sdio_bus_pkg.sv | 13 +
 rtl/sdio_bus_mem.sv | 24 ++
 rtl/sdio_bus_target.sv | 122 ++++++++++++
 tb/tb_sdio_bus_target.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdio_bus_pkg.sv
// Shared definitions for the SDIO-style bus target: FSM encodings and the
// value returned for reads that miss the decoded window.
package sdio_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  localparam logic [7:0] OOR_RDATA = 8'hFF;

endpackage

// File: rtl/sdio_bus_mem.sv
// Byte-wide target memory: synchronous write, registered synchronous read.
// Deliberately has no reset so contents survive a bus reset.
module sdio_bus_mem
  import sdio_bus_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdio_bus_target.sv
// Bus target with programmable wait states in front of a small byte memory;
// tracks sticky errors and accepted read/write counts.
module sdio_bus_target
  import sdio_bus_pkg::*;
#(
  parameter int LEN  = 16,
  parameter int AW   = 8,
  parameter int BASE = 0
) (
  input  logic           bus_clk,
  input  logic           rst,
  input  logic [LEN-1:0] bus_addr,
  input  logic [7:0]     bus_wdata,
  input  logic           bus_rd,
  input  logic           bus_wr,
  input  logic [3:0]     wait_cfg,
  input  logic           err_clr,
  output logic           bus_ready,
  output logic           bus_rdata_ready,
  output logic [7:0]     bus_rdata,
  output logic           err,
  output logic [15:0]    wr_cnt,
  output logic [15:0]    rd_cnt,
  output logic [1:0]     tgt_state
);

  // Window bounds carry one extra bit so BASE+2^AW cannot wrap.
  localparam logic [LEN:0] LO = (LEN+1)'(BASE);
  localparam logic [LEN:0] HI = LO + (LEN+1)'(2**AW);

  state_t        state, state_nx;
  logic [3:0]    wcnt;
  logic          read_q;
  logic          oor_q;
  logic [7:0]    rdata_q;
  logic [7:0]    mem_q;
  logic [7:0]    data_out;
  logic          accept;
  logic          is_rd;
  logic          is_wr;
  logic          proto_err;
  logic          in_range;
  logic [AW-1:0] idx;

  assign is_rd     = bus_rd & ~bus_wr;
  assign is_wr     = bus_wr & ~bus_rd;
  assign proto_err = bus_rd & bus_wr;
  assign accept    = (state == ST_IDLE) & (bus_rd | bus_wr);
  assign in_range  = ({1'b0, bus_addr} >= LO) && ({1'b0, bus_addr} < HI);
  assign idx       = bus_addr[AW-1:0] - LO[AW-1:0];
  assign data_out  = oor_q ? OOR_RDATA : mem_q;

  sdio_bus_mem #(.AW(AW)) u_mem (
    .clk   (bus_clk),
    .we    (accept & is_wr & in_range),
    .waddr (idx),
    .wdata (bus_wdata),
    .re    (accept & is_rd),
    .raddr (idx),
    .rdata (mem_q)
  );

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // A protocol-error request is tracked as a non-read so it finishes with write timing.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (wait_cfg != 4'd0) state_nx = ST_WAIT;
          else if (is_rd)       state_nx = ST_RDATA;
        end
      end
      ST_WAIT:  if (wcnt == 4'd1) state_nx = read_q ? ST_RDATA : ST_IDLE;
      ST_RDATA: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_ready       = (state == ST_IDLE);
    bus_rdata_ready = (state == ST_RDATA);
    tgt_state       = state;
    bus_rdata       = (state == ST_RDATA) ? data_out : rdata_q;
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      wcnt    <= 4'd0;
      read_q  <= 1'b0;
      oor_q   <= 1'b0;
      rdata_q <= 8'd0;
    end else begin
      if (accept) begin
        wcnt   <= wait_cfg;
        read_q <= is_rd;
        oor_q  <= ~in_range;
      end else if (state == ST_WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
      if (state == ST_RDATA) rdata_q <= data_out;
    end
  end

  // A new error wins over a simultaneous clear.
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      err    <= 1'b0;
      wr_cnt <= 16'd0;
      rd_cnt <= 16'd0;
    end else begin
      err <= (err & ~err_clr) | (accept & (proto_err | ~in_range));
      if (accept & is_wr) wr_cnt <= wr_cnt + 16'd1;
      if (accept & is_rd) rd_cnt <= rd_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sdio_bus_target.sv
// Scoreboard bench for sdio_bus_target: a reference memory predicts read data
// and the cycle of each read-data pulse; counters and err are tracked alongside.
`timescale 1ns/1ps
module tb_sdio_bus_target;

  localparam int LEN  = 16;
  localparam int AW   = 8;
  localparam int BASE = 256;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic        bus_clk = 1'b0;
  logic        rst;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [3:0]  wait_cfg;
  logic        err_clr;
  logic        bus_ready;
  logic        bus_rdata_ready;
  logic [7:0]  bus_rdata;
  logic        err;
  logic [15:0] wr_cnt;
  logic [15:0] rd_cnt;
  logic [1:0]  tgt_state;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          acc;
  int          exp_wr   = 0;
  int          exp_rd   = 0;
  logic        exp_err  = 1'b0;
  logic [7:0]  ref_mem [256];
  exp_t        sb [$];
  exp_t        mon_e;

  sdio_bus_target #(.LEN(LEN), .AW(AW), .BASE(BASE)) dut (
    .bus_clk         (bus_clk),
    .rst             (rst),
    .bus_addr        (bus_addr),
    .bus_wdata       (bus_wdata),
    .bus_rd          (bus_rd),
    .bus_wr          (bus_wr),
    .wait_cfg        (wait_cfg),
    .err_clr         (err_clr),
    .bus_ready       (bus_ready),
    .bus_rdata_ready (bus_rdata_ready),
    .bus_rdata       (bus_rdata),
    .err             (err),
    .wr_cnt          (wr_cnt),
    .rd_cnt          (rd_cnt),
    .tgt_state       (tgt_state)
  );

  always #5 bus_clk = ~bus_clk;

  always @(posedge bus_clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // Every rdata pulse must match the oldest outstanding predicted read.
  always @(negedge bus_clk) begin
    if (!rst && bus_rdata_ready) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_rdata", 32'(bus_rdata_ready), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("rdata", 32'(bus_rdata), 32'(mon_e.data));
        checkOutput("rdata_cycle", cyc, mon_e.due);
      end
    end
  end

  // Called at a falling edge; presents one request and returns at the falling edge after accept.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [7:0] data, input logic [3:0] w, output int acc_cyc);
    int   n = 0;
    logic inr;
    exp_t e;
    while (!bus_ready && n < 100) begin
      @(negedge bus_clk);
      n++;
    end
    if (!bus_ready) checkOutput("ready_timeout", 32'(bus_ready), 32'd1);
    bus_rd    = rd;
    bus_wr    = wr;
    bus_addr  = addr;
    bus_wdata = data;
    wait_cfg  = w;
    acc_cyc   = cyc;
    inr = (int'(addr) >= BASE) && (int'(addr) < BASE + 256);
    if (rd && wr) exp_err = 1'b1;
    else if (!inr) exp_err = 1'b1;
    if (wr && !rd) begin
      exp_wr++;
      if (inr) ref_mem[8'(int'(addr) - BASE)] = data;
    end
    if (rd && !wr) begin
      exp_rd++;
      e.data = inr ? ref_mem[8'(int'(addr) - BASE)] : 8'hFF;
      e.due  = acc_cyc + int'(w) + 1;
      sb.push_back(e);
    end
    @(posedge bus_clk);
    @(negedge bus_clk);
    bus_rd = 1'b0;
    bus_wr = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(negedge bus_clk);
      n++;
    end while ((!bus_ready || sb.size() != 0) && n < 200);
    checkOutput("idle_timeout", 32'(bus_ready), 32'd1);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(exp_wr[15:0]));
    checkOutput({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(exp_rd[15:0]));
    checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge bus_clk);
    rst = 1'b0;
    exp_wr  = 0;
    exp_rd  = 0;
    exp_err = 1'b0;
  endtask

  initial begin
    int busy;
    rst       = 1'b1;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    wait_cfg  = '0;
    err_clr   = 1'b0;
    repeat (3) @(negedge bus_clk);
    checkOutput("rst_ready", 32'(bus_ready), 32'd1);
    checkOutput("rst_rdata_ready", 32'(bus_rdata_ready), 32'd0);
    checkOutput("rst_rdata", 32'(bus_rdata), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    checkOutput("rst_rd_cnt", 32'(rd_cnt), 32'd0);
    checkOutput("rst_state", 32'(tgt_state), 32'd0);
    rst = 1'b0;
    @(negedge bus_clk);

    $display("[TB] write with wait states, then read back");
    applyStimulus(1'b0, 1'b1, 16'(BASE + 3), 8'h5A, 4'd2, acc);
    busy = 0;
    while (!bus_ready && busy < 20) begin
      busy++;
      @(negedge bus_clk);
    end
    checkOutput("wr_busy_cycles", busy, 2);
    applyStimulus(1'b1, 1'b0, 16'(BASE + 3), 8'h00, 4'd2, acc);
    waitIdle();

    $display("[TB] zero-wait read, back-to-back after write");
    applyStimulus(1'b0, 1'b1, 16'(BASE + 'h10), 8'hC3, 4'd0, acc);
    checkOutput("wr0_ready_stays", 32'(bus_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'(BASE + 'h10), 8'h00, 4'd0, acc);
    checkOutput("rd0_ready_acc1", 32'(bus_ready), 32'd0);
    @(negedge bus_clk);
    checkOutput("rd0_ready_acc2", 32'(bus_ready), 32'd1);
    checkOutput("rdata_hold", 32'(bus_rdata), 32'hC3);
    checkCounters("rd0");

    $display("[TB] out-of-range access");
    applyStimulus(1'b0, 1'b1, 16'(BASE), 8'h11, 4'd0, acc);
    applyStimulus(1'b0, 1'b1, 16'(BASE + 256), 8'h77, 4'd1, acc);
    applyStimulus(1'b1, 1'b0, 16'(BASE + 256), 8'h00, 4'd0, acc);
    applyStimulus(1'b1, 1'b0, 16'(BASE - 1), 8'h00, 4'd3, acc);
    applyStimulus(1'b1, 1'b0, 16'(BASE), 8'h00, 4'd1, acc);
    waitIdle();
    checkCounters("oor");
    err_clr = 1'b1;
    @(negedge bus_clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    checkOutput("err_cleared", 32'(err), 32'd0);
    err_clr = 1'b1;
    applyStimulus(1'b1, 1'b0, 16'(BASE + 256), 8'h00, 4'd0, acc);
    err_clr = 1'b0;
    checkOutput("err_clr_vs_new", 32'(err), 32'd1);
    waitIdle();
    err_clr = 1'b1;
    @(negedge bus_clk);
    err_clr = 1'b0;
    exp_err = 1'b0;

    $display("[TB] protocol error");
    applyStimulus(1'b0, 1'b1, 16'(BASE + 5), 8'h42, 4'd0, acc);
    applyStimulus(1'b1, 1'b1, 16'(BASE + 5), 8'hEE, 4'd2, acc);
    busy = 0;
    while (!bus_ready && busy < 20) begin
      busy++;
      @(negedge bus_clk);
    end
    checkOutput("proto_busy_cycles", busy, 2);
    checkCounters("proto");
    applyStimulus(1'b1, 1'b0, 16'(BASE + 5), 8'h00, 4'd0, acc);
    waitIdle();
    err_clr = 1'b1;
    @(negedge bus_clk);
    err_clr = 1'b0;
    exp_err = 1'b0;

    $display("[TB] requests while busy are ignored");
    applyStimulus(1'b0, 1'b1, 16'(BASE + 'h40), 8'h12, 4'd0, acc);
    applyStimulus(1'b1, 1'b0, 16'(BASE + 'h40), 8'h00, 4'd3, acc);
    bus_wr    = 1'b1;
    bus_addr  = 16'(BASE + 'h40);
    bus_wdata = 8'hAB;
    wait_cfg  = 4'd0;
    repeat (2) @(negedge bus_clk);
    bus_wr = 1'b0;
    waitIdle();
    checkCounters("busy_ignore");
    applyStimulus(1'b1, 1'b0, 16'(BASE + 'h40), 8'h00, 4'd0, acc);
    waitIdle();

    $display("[TB] reset during read wait");
    applyStimulus(1'b0, 1'b1, 16'(BASE + 'h20), 8'h9C, 4'd1, acc);
    waitIdle();
    bus_rd   = 1'b1;
    bus_addr = 16'(BASE + 'h20);
    wait_cfg = 4'd5;
    @(posedge bus_clk);
    @(negedge bus_clk);
    bus_rd = 1'b0;
    checkOutput("abort_in_wait", 32'(tgt_state), 32'd1);
    @(negedge bus_clk);
    pulseReset();
    checkOutput("abort_ready", 32'(bus_ready), 32'd1);
    checkOutput("abort_state", 32'(tgt_state), 32'd0);
    checkOutput("abort_rdata", 32'(bus_rdata), 32'd0);
    checkCounters("abort");
    repeat (8) @(negedge bus_clk);
    applyStimulus(1'b1, 1'b0, 16'(BASE + 'h20), 8'h00, 4'd4, acc);
    applyStimulus(1'b1, 1'b0, 16'(BASE + 3), 8'h00, 4'd0, acc);
    waitIdle();

    $display("[TB] sequential DMA-style traffic");
    pulseReset();
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, 1'b1, 16'(BASE + (i % 256)), 8'(i), 4'($urandom_range(0, 15)), acc);
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b1, 1'b0, 16'(BASE + (i % 256)), 8'h00, 4'($urandom_range(0, 15)), acc);
    waitIdle();
    checkOutput("dma_wr_cnt", 32'(wr_cnt), 32'd300);
    checkOutput("dma_rd_cnt", 32'(rd_cnt), 32'd300);
    checkCounters("dma");
    checkOutput("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
